des_key_schedule: RTL and testbench
===================================

// Module: des_key_schedule
// PURPOSE
//  Sequential DES key schedule; upstream stage of the round function.
//  Accepts a 64-bit key, applies PC-1, rotates C/D halves per round and emits 16 48-bit PC-2 round keys.
//  Each key goes out over a valid/ready handshake to the round engine, which drives the round function's key input.
//  Encrypt order is K1..K16; decrypt order is K16..K1, produced by right rotation (no key storage).
// PARAMETERS
//  NUM_ROUNDS  16  rounds per key; only 16 is supported, elaborates for the shift table.
//  ROUND_W     4   width of o_round; must hold NUM_ROUNDS-1.
// PORTS
//  i_clk          in   1   single clock; all state on rising edge.
//  i_rst_n        in   1   asynchronous, active-low reset.
//  i_start        in   1   start request; accepted only when o_ready=1.
//  i_key          in   64  DES key; bit 1 (DES numbering) = i_key[63]; sampled on accepted start.
//  i_decrypt      in   1   0 = encrypt order, 1 = decrypt order; sampled on accepted start.
//  i_abort        in   1   synchronous abort to IDLE; priority over everything except reset.
//  o_ready        out  1   1 in IDLE; start can be accepted.
//  o_key_valid    out  1   o_round_key holds a valid round key.
//  i_key_ready    in   1   consumer takes the key when o_key_valid & i_key_ready.
//  o_round_key    out  48  PC-2 of the current C/D registers.
//  o_round        out  ROUND_W  sequence index 0..15 (position in emitted order, not key number).
//  o_done         out  1   one-cycle pulse after the 16th key handshake.
// BEHAVIOUR
//  Reset: state=IDLE; C=D=0; o_ready=1; o_key_valid=0; o_round=0; o_done=0; o_round_key=48'h0.
//  States: IDLE -> RUN on i_start & o_ready. RUN -> IDLE on the handshake at o_round=15 (o_done=1 next cycle).
//  Any state -> IDLE on i_abort, with no o_done.
//  Shift table S[0..15] = {1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1}. C/D are 28 bits each; rotation is within each half.
//  Start, encrypt: {C,D} <= rotl(PC1(i_key), S[0]). Start, decrypt: {C,D} <= PC1(i_key); unrotated, because total shift = 28.
//  Latency: first key valid on the cycle after start acceptance. o_round=0.
//  Advance (handshake at n<15): o_round <= n+1.
//    Encrypt: C/D rotl by S[n+1]. Decrypt: C/D rotr by S[15-n].
//  o_key_valid=1 throughout RUN. o_round_key, o_round stable while valid & !ready.
//  Max throughput: one key per cycle with i_key_ready tied high; no bubble between keys.
//  i_start in RUN: ignored; no queueing. i_key and i_decrypt are not used after sampling.
//  Start and abort in the same cycle from IDLE: abort wins; stays IDLE.
//  o_done=1 and o_ready=1 coincide on the first IDLE cycle. A new start accepted that cycle is legal.
//  o_round_key is combinational from C/D registers only; no input-to-output combinational path.
// CONFIGURATION
//  DES_KEY_PARITY_CHECK_EN defined:
//    Adds output o_parity_err (1 bit, reset 0), registered on accepted start.
//    It is 1 if any byte of i_key has even parity; DES requires odd parity per byte.
//    Held until the next accepted start or reset. Key generation proceeds regardless.
//  Undefined: port and logic absent; parity bits are ignored, as PC-1 drops them.
// STRUCTURE
//  Package des_key_sched_pkg:
//    PC1 table (56 entries), PC2 table (48), shift table S, C/D width constant (28), state enum {IDLE,RUN}.
//    Tables use DES 1-based numbering, MSB-first.
//  Sub-module des_pc2_permute (56->48, combinational, from PC2 table).
//  PC-1 and the rotation muxes stay inline in the top.
// TESTING
//  T1 encrypt, key 64'h133457799BBCDFF1, ready=1:
//    round0 key = 48'h1B02EFFC7072; round15 key = 48'hCB3D8B0E17F5.
//    16 consecutive valid cycles, then o_done pulse.
//  T2 same key, decrypt: round0 key = 48'hCB3D8B0E17F5, round15 key = 48'h1B02EFFC7072.
//    The full sequence is the exact reverse of T1.
//  T3 backpressure: i_key_ready random 30%.
//    Key and o_round are held while stalled; sequence is identical to T1.
//  T4 i_start pulsed at round 5 with a different key -> ignored; T1 sequence completes unchanged.
//  T5 i_abort at round 7 -> IDLE next cycle; o_done stays 0. A restart yields a full 16-key sequence from round 0.
//  T6 i_rst_n low mid-RUN -> all outputs at reset values immediately.
//    With DES_KEY_PARITY_CHECK_EN: key 64'h0 -> o_parity_err=1; key 64'h0101010101010101 -> 0.

Source files
------------

// File: rtl/des_key_sched_pkg.sv
// DES key-schedule constants: PC-1/PC-2/shift tables (DES 1-based, MSB-first),
// half-rotation helpers and the sequencer state type.
package des_key_sched_pkg;

    localparam int KEY_W = 64;
    localparam int CD_W  = 28;
    localparam int RK_W  = 48;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int PC1_TABLE [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TABLE [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam int SHIFT_TABLE [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    function automatic logic [CD_W-1:0] rotl_half(input logic [CD_W-1:0] v, input logic two);
        return two ? {v[CD_W-3:0], v[CD_W-1:CD_W-2]} : {v[CD_W-2:0], v[CD_W-1]};
    endfunction

    function automatic logic [CD_W-1:0] rotr_half(input logic [CD_W-1:0] v, input logic two);
        return two ? {v[1:0], v[CD_W-1:2]} : {v[0], v[CD_W-1:1]};
    endfunction

    // DES wants odd parity in every key byte; flag any byte that is even.
    function automatic logic key_parity_err(input logic [KEY_W-1:0] k);
        logic err;
        err = 1'b0;
        for (int b = 0; b < KEY_W / 8; b++) err |= ~(^k[8*b +: 8]);
        return err;
    endfunction

endpackage

// File: rtl/des_pc2_permute.sv
// Combinational PC-2 compression: 56-bit {C,D} to a 48-bit DES round key.
module des_pc2_permute
    import des_key_sched_pkg::*;
(
    input  logic [2*CD_W-1:0] i_cd,
    output logic [RK_W-1:0]   o_round_key
);

    always_comb begin
        // NOTE: default first so no path through the block leaves the output unassigned (no latch).
        o_round_key = '0;
        for (int j = 0; j < RK_W; j++) begin
            o_round_key[RK_W-1-j] = i_cd[2*CD_W - PC2_TABLE[j]];
        end
    end

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule emitting 16 round keys over valid/ready, encrypt or decrypt order.
// Optional key parity flag when DES_KEY_PARITY_CHECK_EN is defined.
module des_key_schedule
    import des_key_sched_pkg::*;
#(
    parameter int NUM_ROUNDS = 16,
    parameter int ROUND_W    = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [KEY_W-1:0]    i_key,
    input  logic                i_decrypt,
    input  logic                i_abort,
    output logic                o_ready,
    output logic                o_key_valid,
    input  logic                i_key_ready,
    output logic [RK_W-1:0]     o_round_key,
    output logic [ROUND_W-1:0]  o_round,
`ifdef DES_KEY_PARITY_CHECK_EN
    output logic                o_parity_err,
`endif
    output logic                o_done
);

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

    state_t               r_state;
    logic [CD_W-1:0]      r_c;
    logic [CD_W-1:0]      r_d;
    logic [ROUND_W-1:0]   r_round;
    logic                 r_decrypt;
    logic                 r_done;

    logic [2*CD_W-1:0]    w_pc1;
    logic [ROUND_W-1:0]   w_adv_idx;
    logic                 w_adv_two;
    logic                 w_start_two;
    logic                 w_accept;

    always_comb begin
        w_pc1 = '0;
        for (int j = 0; j < 2*CD_W; j++) begin
            w_pc1[2*CD_W-1-j] = i_key[KEY_W - PC1_TABLE[j]];
        end
    end

    // Decrypt walks the table backwards with right rotations, so no keys need storing.
    assign w_adv_idx   = r_decrypt ? ROUND_W'(LAST_ROUND - r_round) : ROUND_W'(r_round + 1'b1);
    assign w_adv_two   = (SHIFT_TABLE[w_adv_idx] == 2);
    assign w_start_two = (SHIFT_TABLE[0] == 2);
    assign w_accept    = (r_state == IDLE) && i_start && !i_abort;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_c       <= '0;
            r_d       <= '0;
            r_round   <= '0;
            r_decrypt <= 1'b0;
            r_done    <= 1'b0;
        end else if (i_abort) begin
            r_state <= IDLE;
            r_round <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state   <= RUN;
                        r_round   <= '0;
                        r_decrypt <= i_decrypt;
                        if (i_decrypt) begin
                            r_c <= w_pc1[2*CD_W-1:CD_W];
                            r_d <= w_pc1[CD_W-1:0];
                        end else begin
                            r_c <= rotl_half(w_pc1[2*CD_W-1:CD_W], w_start_two);
                            r_d <= rotl_half(w_pc1[CD_W-1:0], w_start_two);
                        end
                    end
                end
                RUN: begin
                    if (i_key_ready) begin
                        if (r_round == LAST_ROUND) begin
                            r_state <= IDLE;
                            r_round <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_round <= r_round + 1'b1;
                            if (r_decrypt) begin
                                r_c <= rotr_half(r_c, w_adv_two);
                                r_d <= rotr_half(r_d, w_adv_two);
                            end else begin
                                r_c <= rotl_half(r_c, w_adv_two);
                                r_d <= rotl_half(r_d, w_adv_two);
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef DES_KEY_PARITY_CHECK_EN
    logic r_parity_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_parity_err <= 1'b0;
        end else if (w_accept) begin
            r_parity_err <= key_parity_err(i_key);
        end
    end

    assign o_parity_err = r_parity_err;
`else
    logic w_unused_parity;
    assign w_unused_parity = ^{i_key[56], i_key[48], i_key[40], i_key[32],
                               i_key[24], i_key[16], i_key[8],  i_key[0], w_accept};
`endif

    des_pc2_permute u_pc2 (
        .i_cd        ({r_c, r_d}),
        .o_round_key (o_round_key)
    );

    assign o_ready     = (r_state == IDLE);
    assign o_key_valid = (r_state == RUN);
    assign o_round     = r_round;
    assign o_done      = r_done;

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: randomized keys/backpressure against a
// cumulative-shift reference model, plus the known DES key vector.
module tb_des_key_schedule;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [63:0] i_key = '0;
    logic        i_decrypt = 1'b0;
    logic        i_abort = 1'b0;
    logic        i_key_ready = 1'b0;
    logic        o_ready;
    logic        o_key_valid;
    logic [47:0] o_round_key;
    logic [3:0]  o_round;
    logic        o_done;
`ifdef DES_KEY_PARITY_CHECK_EN
    logic        o_parity_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [47:0] exp_keys [16];
    logic [47:0] obs_keys [16];

    localparam logic [63:0] KEY_T1 = 64'h133457799BBCDFF1;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    always #5 i_clk = ~i_clk;

    des_key_schedule #(.NUM_ROUNDS(16), .ROUND_W(4)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_key        (i_key),
        .i_decrypt    (i_decrypt),
        .i_abort      (i_abort),
        .o_ready      (o_ready),
        .o_key_valid  (o_key_valid),
        .i_key_ready  (i_key_ready),
        .o_round_key  (o_round_key),
        .o_round      (o_round),
`ifdef DES_KEY_PARITY_CHECK_EN
        .o_parity_err (o_parity_err),
`endif
        .o_done       (o_done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Key K(r) uses C0/D0 rotated left by the running total of shifts up to round r.
    task automatic build_model(input logic [63:0] key, input logic dec);
        logic [55:0] cd0;
        logic [55:0] cc;
        logic [55:0] dd;
        logic [55:0] src;
        logic [27:0] c;
        logic [27:0] d;
        logic [47:0] enc [16];
        int tot;
        tot = 0;
        for (int j = 0; j < 56; j++) cd0[55-j] = key[64 - PC1[j]];
        cc = {cd0[55:28], cd0[55:28]};
        dd = {cd0[27:0], cd0[27:0]};
        for (int r = 0; r < 16; r++) begin
            tot += SHIFTS[r];
            c = cc[55-tot -: 28];
            d = dd[55-tot -: 28];
            src = {c, d};
            for (int j = 0; j < 48; j++) enc[r][47-j] = src[56 - PC2[j]];
        end
        for (int i = 0; i < 16; i++) exp_keys[i] = dec ? enc[15-i] : enc[i];
    endtask

    task automatic start_run(input logic [63:0] key, input logic dec);
        check("ready_before_start", o_ready, 1'b1);
        i_key     = key;
        i_decrypt = dec;
        i_start   = 1'b1;
        @(negedge i_clk);
        i_start   = 1'b0;
        i_key     = {$urandom, $urandom};
        i_decrypt = 1'($urandom_range(1));
    endtask

    task automatic run_seq(input logic [63:0] key, input logic dec, input int pct,
                           input int start_at, input int abort_at);
        int   idx;
        int   guard;
        logic rdy;
        logic aborted;
        idx = 0;
        guard = 0;
        aborted = 1'b0;
        build_model(key, dec);
        start_run(key, dec);
        while (idx < 16 && guard < 1000 && !aborted) begin
            check("key_valid", o_key_valid, 1'b1);
            check("round_idx", o_round, idx);
            check("round_key", o_round_key, exp_keys[idx]);
            check("done_during_run", o_done, 1'b0);
            obs_keys[idx] = o_round_key;
            rdy = ($urandom_range(99) < pct);
            i_key_ready = rdy;
            if (idx == start_at) begin
                i_start   = 1'b1;
                i_key     = ~key;
                i_decrypt = ~dec;
            end
            if (idx == abort_at) i_abort = 1'b1;
            @(negedge i_clk);
            guard++;
            i_start = 1'b0;
            if (i_abort) begin
                i_abort = 1'b0;
                aborted = 1'b1;
            end else if (rdy) begin
                idx++;
            end
        end
        if (aborted) begin
            check("abort_ready", o_ready, 1'b1);
            check("abort_valid", o_key_valid, 1'b0);
            check("abort_done", o_done, 1'b0);
            @(negedge i_clk);
            check("abort_done_late", o_done, 1'b0);
        end else begin
            check("seq_complete", idx, 16);
            if (pct >= 100) check("no_bubble_cycles", guard, 16);
            check("done_pulse", o_done, 1'b1);
            check("ready_at_done", o_ready, 1'b1);
            check("valid_after_seq", o_key_valid, 1'b0);
            @(negedge i_clk);
            check("done_cleared", o_done, 1'b0);
        end
        i_key_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge i_clk);
        check("rst_ready", o_ready, 1'b1);
        check("rst_valid", o_key_valid, 1'b0);
        check("rst_round", o_round, 0);
        check("rst_done", o_done, 1'b0);
        check("rst_key", o_round_key, 48'h0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // T1: known vector, encrypt, full throughput
        run_seq(KEY_T1, 1'b0, 100, -1, -1);
        check("t1_round0_key", obs_keys[0], 48'h1B02EFFC7072);
        check("t1_round15_key", obs_keys[15], 48'hCB3D8B0E17F5);

        // T2: decrypt order is the reverse
        run_seq(KEY_T1, 1'b1, 100, -1, -1);
        check("t2_round0_key", obs_keys[0], 48'hCB3D8B0E17F5);
        check("t2_round15_key", obs_keys[15], 48'h1B02EFFC7072);

        // T3: heavy backpressure
        run_seq(KEY_T1, 1'b0, 30, -1, -1);

        // T4: start during RUN is ignored
        run_seq(KEY_T1, 1'b0, 100, 5, -1);

        // T5: abort at round 7, then a clean restart
        run_seq(KEY_T1, 1'b0, 100, -1, 7);
        run_seq(KEY_T1, 1'b0, 100, -1, -1);

        // Start and abort together from IDLE: abort wins
        i_start = 1'b1;
        i_abort = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        i_abort = 1'b0;
        check("start_abort_stays_idle", o_ready, 1'b1);
        check("start_abort_no_valid", o_key_valid, 1'b0);

        // Randomized keys, order and backpressure
        repeat (8) run_seq({$urandom, $urandom}, 1'($urandom_range(1)), 70, -1, -1);

`ifdef DES_KEY_PARITY_CHECK_EN
        start_run(64'h0101010101010101, 1'b0);
        check("parity_ok_key", o_parity_err, 1'b0);
        i_abort = 1'b1;
        @(negedge i_clk);
        i_abort = 1'b0;
        start_run(64'h0, 1'b0);
        check("parity_zero_key", o_parity_err, 1'b1);
        i_abort = 1'b1;
        @(negedge i_clk);
        i_abort = 1'b0;
        check("parity_held_after_abort", o_parity_err, 1'b1);
`endif

        // T6: reset mid-RUN
        start_run(64'h0, 1'b0);
        i_key_ready = 1'b1;
        repeat (4) @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        check("midrst_ready", o_ready, 1'b1);
        check("midrst_valid", o_key_valid, 1'b0);
        check("midrst_round", o_round, 0);
        check("midrst_done", o_done, 1'b0);
        check("midrst_key", o_round_key, 48'h0);
`ifdef DES_KEY_PARITY_CHECK_EN
        check("midrst_parity", o_parity_err, 1'b0);
`endif
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_key_ready = 1'b0;
        @(negedge i_clk);
        run_seq(KEY_T1, 1'b1, 100, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
